umi_mux: RTL and testbench

UMI_MUX -- requirements
Module: umi_mux

---
 rtl/umi_mux_pkg.sv | 51 +++++
 rtl/umi_mux_if.sv | 56 +++++
 rtl/umi_priority_arb.sv | 63 ++++++
 rtl/umi_mux.sv | 87 ++++++++
 tb/tb_umi_mux.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/umi_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : umi_mux_pkg
// Description : Shared UMI definitions. Holds the default address and packet
//               widths, the command-field layout and opcodes, the grant
//               encoding used by the arbiter, and a helper that clamps a
//               starvation limit into the 4-bit counter range.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package umi_mux_pkg;

    // Default UMI widths.
    localparam int c_UMI_AW = 64;
    localparam int c_UMI_UW = 256;

    // Command field layout: the command occupies the low word of a packet.
    localparam int c_UMI_CW        = 32;
    localparam int c_UMI_OPCODE_LO = 0;
    localparam int c_UMI_OPCODE_W  = 5;

    // Command opcodes. The mux never decodes them; they are shared here so
    // every UMI block agrees on the encoding.
    localparam logic [4:0] c_UMI_REQ_READ   = 5'h01;
    localparam logic [4:0] c_UMI_REQ_WRITE  = 5'h03;
    localparam logic [4:0] c_UMI_REQ_POSTED = 5'h05;
    localparam logic [4:0] c_UMI_RESP_READ  = 5'h02;
    localparam logic [4:0] c_UMI_RESP_WRITE = 5'h04;

    // One-hot-ish grant encoding between the two input streams.
    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_0    = 2'b01,
        GRANT_1    = 2'b10
    } grant_e;

    // The starvation counter is 4 bits wide, so the limit must be 1..15.
    function automatic logic [3:0] starve_cap(input int starve);
        logic [31:0] v;
        v = starve;
        if (starve < 1) begin
            return 4'd1;
        end
        if (starve > 15) begin
            return 4'd15;
        end
        return v[3:0];
    endfunction

endpackage : umi_mux_pkg
`default_nettype wire

// File: rtl/umi_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : umi_mux_if
// Description : Bundle of the two input UMI streams and the merged output
//               stream of the UMI mux.
// Ports       : umi0_in_*  high-priority (write) stream  valid/packet/ready
//               umi1_in_*  low-priority (read) stream     valid/packet/ready
//               umi_out_*  merged output stream           valid/packet/ready
//               modport slave  : view of the mux itself
//               modport master : view of the surrounding logic
// Revision    : 1.0 - initial release
// ============================================================================
interface umi_mux_if
    import umi_mux_pkg::*;
#(
    parameter int UW = c_UMI_UW
);

    logic          umi0_in_valid;
    logic [UW-1:0] umi0_in_packet;
    logic          umi0_in_ready;

    logic          umi1_in_valid;
    logic [UW-1:0] umi1_in_packet;
    logic          umi1_in_ready;

    logic          umi_out_valid;
    logic [UW-1:0] umi_out_packet;
    logic          umi_out_ready;

    modport slave (
        input  umi0_in_valid,
        input  umi0_in_packet,
        output umi0_in_ready,
        input  umi1_in_valid,
        input  umi1_in_packet,
        output umi1_in_ready,
        output umi_out_valid,
        output umi_out_packet,
        input  umi_out_ready
    );

    modport master (
        output umi0_in_valid,
        output umi0_in_packet,
        input  umi0_in_ready,
        output umi1_in_valid,
        output umi1_in_packet,
        input  umi1_in_ready,
        input  umi_out_valid,
        input  umi_out_packet,
        output umi_out_ready
    );

endinterface : umi_mux_if
`default_nettype wire

// File: rtl/umi_priority_arb.sv
`default_nettype none
// ============================================================================
// Module      : umi_priority_arb
// Description : Fixed-priority arbiter with starvation relief. umi0 wins by
//               default; once umi0 has been accepted STARVE times in a row
//               while umi1 was waiting, umi1 gets one grant.
// Ports       : clk, reset          clock, asynchronous active-high reset
//               umi0_valid/umi1_valid  request lines
//               umi0_accept/umi1_accept completed-transfer strobes
//               grant0/grant1         combinational grants
// Revision    : 1.0 - initial release
// ============================================================================
module umi_priority_arb
    import umi_mux_pkg::*;
#(
    parameter int STARVE = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic umi0_valid,
    input  wire logic umi1_valid,
    input  wire logic umi0_accept,
    input  wire logic umi1_accept,
    output logic      grant0,
    output logic      grant1
);

    localparam logic [3:0] c_STARVE = starve_cap(STARVE);

    logic [3:0] r_cnt;
    logic       w_starved;
    grant_e     w_grant;

    assign w_starved = (r_cnt == c_STARVE);

    // Grants look only at the valids and the counter, never at packet data,
    // so the ready path stays independent of payload contents.
    always_comb begin
        w_grant = GRANT_NONE;
        if (umi1_valid && (!umi0_valid || w_starved)) begin
            w_grant = GRANT_1;
        end else if (umi0_valid) begin
            w_grant = GRANT_0;
        end
    end

    assign grant0 = (w_grant == GRANT_0);
    assign grant1 = (w_grant == GRANT_1);

    // Counts consecutive umi0 wins while umi1 is waiting. Any umi1 transfer,
    // or umi1 going idle, wipes the history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 4'd0;
        end else if (!umi1_valid || umi1_accept) begin
            r_cnt <= 4'd0;
        end else if (umi0_accept && !w_starved) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

endmodule : umi_priority_arb
`default_nettype wire

// File: rtl/umi_mux.sv
`default_nettype none
// ============================================================================
// Module      : umi_mux
// Description : Merges a high-priority (write) and a low-priority (read
//               request) UMI stream into one registered output stream. A
//               single output slot holds one packet; it accepts a new packet
//               in the same cycle it drains, so one packet per cycle flows.
// Ports       : clk    single clock, rising edge
//               reset  asynchronous active-high reset
//               umi    umi_mux_if.slave : umi0_in_*, umi1_in_*, umi_out_*
// Revision    : 1.0 - initial release
// ============================================================================
module umi_mux
    import umi_mux_pkg::*;
#(
    parameter int AW     = c_UMI_AW,
    parameter int UW     = c_UMI_UW,
    parameter int STARVE = 4
) (
    input  wire logic  clk,
    input  wire logic  reset,
    umi_mux_if.slave   umi
);

    // The address field lives inside the packet, so it can never be wider.
    if (AW < 1 || AW > UW) begin : g_bad_aw
        $error("umi_mux: AW must be in 1..UW");
    end

    logic          r_out_valid;
    logic [UW-1:0] r_out_packet;

    logic w_open;
    logic w_grant0;
    logic w_grant1;
    logic w_ready0;
    logic w_ready1;
    logic w_xfer0;
    logic w_xfer1;

    umi_priority_arb #(
        .STARVE (STARVE)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .umi0_valid  (umi.umi0_in_valid),
        .umi1_valid  (umi.umi1_in_valid),
        .umi0_accept (w_xfer0),
        .umi1_accept (w_xfer1),
        .grant0      (w_grant0),
        .grant1      (w_grant1)
    );

    // The slot can take a packet when empty or when it drains this cycle.
    assign w_open = !r_out_valid || umi.umi_out_ready;

    // Reset gates the readies directly: the slot looks empty during reset,
    // but nothing may be accepted until reset is released.
    assign w_ready0 = w_grant0 && w_open && !reset;
    assign w_ready1 = w_grant1 && w_open && !reset;

    assign w_xfer0 = umi.umi0_in_valid && w_ready0;
    assign w_xfer1 = umi.umi1_in_valid && w_ready1;

    assign umi.umi0_in_ready = w_ready0;
    assign umi.umi1_in_ready = w_ready1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_packet <= '0;
        end else if (w_open) begin
            r_out_valid <= w_xfer0 || w_xfer1;
            // Packet register holds its last value when nothing loads.
            if (w_xfer0) begin
                r_out_packet <= umi.umi0_in_packet;
            end else if (w_xfer1) begin
                r_out_packet <= umi.umi1_in_packet;
            end
        end
    end

    assign umi.umi_out_valid  = r_out_valid;
    assign umi.umi_out_packet = r_out_packet;

endmodule : umi_mux
`default_nettype wire

// File: tb/tb_umi_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_umi_mux
// Description : Self-checking testbench for umi_mux. Directed scenarios plus
//               a randomized run against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_umi_mux;
    import umi_mux_pkg::*;

    localparam int UW     = 256;
    localparam int AW     = 64;
    localparam int STARVE = 4;
    localparam int N_RAND = 10000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    umi_mux_if #(.UW(UW)) umi ();

    umi_mux #(
        .AW     (AW),
        .UW     (UW),
        .STARVE (STARVE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .umi   (umi.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Packet tagged with stream id (MSB) and per-stream sequence number.
    function automatic logic [UW-1:0] make_pkt(input int stream, input int seq);
        logic [UW-1:0] r;
        logic [31:0]   s;
        for (int k = 0; k < UW / 32; k++) begin
            r[k*32 +: 32] = $urandom();
        end
        s = seq;
        r[UW-1]      = stream[0];
        r[UW-2 -: 16] = s[15:0];
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        umi.umi0_in_valid  = 1'b0;
        umi.umi1_in_valid  = 1'b0;
        umi.umi0_in_packet = '0;
        umi.umi1_in_packet = '0;
        umi.umi_out_ready  = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        umi.umi0_in_valid  = 1'b1;
        umi.umi1_in_valid  = 1'b1;
        umi.umi0_in_packet = make_pkt(0, 0);
        umi.umi1_in_packet = make_pkt(1, 0);
        umi.umi_out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (umi.umi_out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid got=%b exp=0", umi.umi_out_valid);
        end
        tests_run++;
        if (umi.umi_out_packet !== '0) begin
            tests_failed++;
            $display("FAIL reset_out_packet got=%0h exp=0", umi.umi_out_packet);
        end
        tests_run++;
        if (umi.umi0_in_ready !== 1'b0 || umi.umi1_in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready got=%b%b exp=00", umi.umi0_in_ready, umi.umi1_in_ready);
        end
        tests_run++;
        if (dut.u_arb.r_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_cnt got=%0d exp=0", dut.u_arb.r_cnt);
        end
        next_cycle();
        reset = 1'b0;
        set_idle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_umi0_stream();
        logic [UW-1:0] exp_pkt;
        umi.umi_out_ready = 1'b1;
        umi.umi1_in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            umi.umi0_in_valid  = 1'b1;
            umi.umi0_in_packet = UW'(i);
            @(negedge clk);
            tests_run++;
            if (umi.umi0_in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL s0_ready i=%0d got=%b exp=1", i, umi.umi0_in_ready);
            end
            tests_run++;
            if (i == 1) begin
                if (umi.umi_out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL s0_first_latency got_valid=%b exp=0", umi.umi_out_valid);
                end
            end else begin
                exp_pkt = UW'(i - 1);
                if (umi.umi_out_valid !== 1'b1 || umi.umi_out_packet !== exp_pkt) begin
                    tests_failed++;
                    $display("FAIL s0_out i=%0d got=%b/%0h exp=1/%0h", i,
                             umi.umi_out_valid, umi.umi_out_packet, exp_pkt);
                end
            end
            next_cycle();
        end
        umi.umi0_in_valid = 1'b0;
        exp_pkt = UW'(8);
        @(negedge clk);
        tests_run++;
        if (umi.umi_out_valid !== 1'b1 || umi.umi_out_packet !== exp_pkt) begin
            tests_failed++;
            $display("FAIL s0_last got=%b/%0h exp=1/8", umi.umi_out_valid, umi.umi_out_packet);
        end
        next_cycle();
        @(negedge clk);
        tests_run++;
        if (umi.umi_out_valid !== 1'b0 || umi.umi_out_packet !== exp_pkt) begin
            tests_failed++;
            $display("FAIL s0_idle_hold got=%b/%0h exp=0/8", umi.umi_out_valid, umi.umi_out_packet);
        end
        next_cycle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_starve();
        logic          exp1;
        logic [UW-1:0] prev_pkt;
        logic [UW-1:0] p0;
        logic [UW-1:0] p1;
        prev_pkt = '0;
        umi.umi_out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            p0 = make_pkt(0, i);
            p1 = make_pkt(1, i);
            umi.umi0_in_valid  = 1'b1;
            umi.umi1_in_valid  = 1'b1;
            umi.umi0_in_packet = p0;
            umi.umi1_in_packet = p1;
            // Four umi0 wins, then one umi1 win, repeating.
            exp1 = ((i % (STARVE + 1)) == STARVE);
            @(negedge clk);
            tests_run++;
            if (umi.umi1_in_ready !== exp1 || umi.umi0_in_ready !== !exp1) begin
                tests_failed++;
                $display("FAIL starve_order i=%0d got=%b%b exp=%b%b", i,
                         umi.umi0_in_ready, umi.umi1_in_ready, !exp1, exp1);
            end
            tests_run++;
            if (dut.u_arb.r_cnt > 4'(STARVE)) begin
                tests_failed++;
                $display("FAIL starve_cnt_max i=%0d got=%0d exp<=%0d", i, dut.u_arb.r_cnt, STARVE);
            end
            if (i > 0) begin
                tests_run++;
                if (umi.umi_out_valid !== 1'b1 || umi.umi_out_packet !== prev_pkt) begin
                    tests_failed++;
                    $display("FAIL starve_out i=%0d got=%0h exp=%0h", i, umi.umi_out_packet, prev_pkt);
                end
            end
            prev_pkt = exp1 ? p1 : p0;
            next_cycle();
        end
        set_idle();
        next_cycle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure();
        logic [UW-1:0] px;
        logic [UW-1:0] py;
        px = make_pkt(0, 100);
        py = make_pkt(0, 101);
        umi.umi_out_ready  = 1'b1;
        umi.umi0_in_valid  = 1'b1;
        umi.umi0_in_packet = px;
        umi.umi1_in_valid  = 1'b0;
        next_cycle();
        umi.umi_out_ready  = 1'b0;
        umi.umi0_in_packet = py;
        umi.umi1_in_valid  = 1'b1;
        umi.umi1_in_packet = make_pkt(1, 100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (umi.umi0_in_ready !== 1'b0 || umi.umi1_in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_ready i=%0d got=%b%b exp=00", i, umi.umi0_in_ready, umi.umi1_in_ready);
            end
            tests_run++;
            if (umi.umi_out_valid !== 1'b1 || umi.umi_out_packet !== px) begin
                tests_failed++;
                $display("FAIL bp_hold i=%0d got=%b/%0h exp=1/%0h", i,
                         umi.umi_out_valid, umi.umi_out_packet, px);
            end
            next_cycle();
        end
        umi.umi_out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (umi.umi0_in_ready !== 1'b1 || umi.umi1_in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_drain_accept got=%b%b exp=10", umi.umi0_in_ready, umi.umi1_in_ready);
        end
        next_cycle();
        set_idle();
        @(negedge clk);
        tests_run++;
        if (umi.umi_out_valid !== 1'b1 || umi.umi_out_packet !== py) begin
            tests_failed++;
            $display("FAIL bp_next got=%b/%0h exp=1/%0h", umi.umi_out_valid, umi.umi_out_packet, py);
        end
        next_cycle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_umi1_alone();
        logic [UW-1:0] prev_pkt;
        logic [UW-1:0] p1;
        prev_pkt = '0;
        umi.umi_out_ready = 1'b1;
        umi.umi0_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p1 = make_pkt(1, 200 + i);
            umi.umi1_in_valid  = 1'b1;
            umi.umi1_in_packet = p1;
            @(negedge clk);
            tests_run++;
            if (umi.umi1_in_ready !== 1'b1 || umi.umi0_in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL u1_ready i=%0d got=%b%b exp=01", i, umi.umi0_in_ready, umi.umi1_in_ready);
            end
            tests_run++;
            if (dut.u_arb.r_cnt !== 4'd0) begin
                tests_failed++;
                $display("FAIL u1_cnt i=%0d got=%0d exp=0", i, dut.u_arb.r_cnt);
            end
            if (i > 0) begin
                tests_run++;
                if (umi.umi_out_valid !== 1'b1 || umi.umi_out_packet !== prev_pkt) begin
                    tests_failed++;
                    $display("FAIL u1_out i=%0d got=%0h exp=%0h", i, umi.umi_out_packet, prev_pkt);
                end
            end
            prev_pkt = p1;
            next_cycle();
        end
        set_idle();
        next_cycle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        logic [UW-1:0] paa;
        logic [UW-1:0] pbb;
        paa = UW'('hAA);
        pbb = UW'('hBB);
        umi.umi_out_ready  = 1'b1;
        umi.umi0_in_valid  = 1'b1;
        umi.umi0_in_packet = paa;
        next_cycle();
        umi.umi_out_ready = 1'b0;
        umi.umi0_in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (umi.umi_out_valid !== 1'b1 || umi.umi_out_packet !== paa) begin
            tests_failed++;
            $display("FAIL rm_loaded got=%b/%0h exp=1/aa", umi.umi_out_valid, umi.umi_out_packet);
        end
        // Assert reset between clock edges: the slot must clear immediately.
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (umi.umi_out_valid !== 1'b0 || umi.umi_out_packet !== '0) begin
            tests_failed++;
            $display("FAIL rm_async_clear got=%b/%0h exp=0/0", umi.umi_out_valid, umi.umi_out_packet);
        end
        next_cycle();
        reset = 1'b0;
        umi.umi_out_ready  = 1'b1;
        umi.umi0_in_valid  = 1'b1;
        umi.umi0_in_packet = pbb;
        @(negedge clk);
        tests_run++;
        if (umi.umi_out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rm_no_stale got=%b/%0h exp=0", umi.umi_out_valid, umi.umi_out_packet);
        end
        next_cycle();
        set_idle();
        @(negedge clk);
        tests_run++;
        if (umi.umi_out_valid !== 1'b1 || umi.umi_out_packet !== pbb) begin
            tests_failed++;
            $display("FAIL rm_first_after got=%b/%0h exp=1/bb", umi.umi_out_valid, umi.umi_out_packet);
        end
        next_cycle();
        next_cycle();
    endtask

    // ------------------------------------------------------------------
    // Reference model: the output slot holds at most one packet; a packet
    // leaves when the consumer is ready. Arbitration follows the priority
    // rule with a run-length limit on consecutive umi0 wins while umi1 waits.
    task automatic test_random();
        logic [UW-1:0] cur_pkt [2];
        logic          pending [2];
        int            in_seq  [2];
        int            out_seq [2];
        logic [UW-1:0] slot_q [$];
        int            run_len;
        logic          v0, v1, ordy, open, w1, e0, e1;
        int            s;
        logic [15:0]   seq;

        set_idle();
        next_cycle();
        next_cycle();
        run_len = 0;
        for (int k = 0; k < 2; k++) begin
            pending[k] = 1'b0;
            in_seq[k]  = 0;
            out_seq[k] = 0;
            cur_pkt[k] = '0;
        end

        for (int c = 0; c < N_RAND + 3; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pending[k]) begin
                    cur_pkt[k] = make_pkt(k, in_seq[k]);
                    pending[k] = 1'b1;
                end
            end
            if (c < N_RAND) begin
                v0   = ($urandom_range(0, 9) < 6);
                v1   = ($urandom_range(0, 9) < 6);
                ordy = ($urandom_range(0, 9) < 7);
            end else begin
                v0   = 1'b0;
                v1   = 1'b0;
                ordy = 1'b1;
            end
            umi.umi0_in_valid  = v0;
            umi.umi1_in_valid  = v1;
            umi.umi0_in_packet = cur_pkt[0];
            umi.umi1_in_packet = cur_pkt[1];
            umi.umi_out_ready  = ordy;
            @(negedge clk);

            open = (slot_q.size() == 0) || ordy;
            w1   = v1 && (!v0 || run_len == STARVE);
            e1   = w1 && open;
            e0   = v0 && !w1 && open;

            tests_run++;
            if (umi.umi0_in_ready !== e0 || umi.umi1_in_ready !== e1) begin
                tests_failed++;
                $display("FAIL rand_ready c=%0d got=%b%b exp=%b%b", c,
                         umi.umi0_in_ready, umi.umi1_in_ready, e0, e1);
            end
            tests_run++;
            if (umi.umi0_in_ready === 1'b1 && umi.umi1_in_ready === 1'b1) begin
                tests_failed++;
                $display("FAIL rand_one_ready c=%0d got=11 exp=at most one", c);
            end
            tests_run++;
            if (umi.umi_out_valid !== (slot_q.size() != 0)) begin
                tests_failed++;
                $display("FAIL rand_out_valid c=%0d got=%b exp=%b", c,
                         umi.umi_out_valid, slot_q.size() != 0);
            end

            if (slot_q.size() != 0 && ordy) begin
                tests_run++;
                if (umi.umi_out_packet !== slot_q[0]) begin
                    tests_failed++;
                    $display("FAIL rand_out_pkt c=%0d got=%0h exp=%0h", c, umi.umi_out_packet, slot_q[0]);
                end
                s   = int'(umi.umi_out_packet[UW-1]);
                seq = umi.umi_out_packet[UW-2 -: 16];
                tests_run++;
                if (int'(seq) !== out_seq[s]) begin
                    tests_failed++;
                    $display("FAIL rand_order c=%0d stream=%0d got_seq=%0d exp_seq=%0d", c, s, seq, out_seq[s]);
                end
                out_seq[s]++;
                void'(slot_q.pop_front());
            end

            if (e0) begin
                slot_q.push_back(cur_pkt[0]);
                pending[0] = 1'b0;
                in_seq[0]++;
            end else if (e1) begin
                slot_q.push_back(cur_pkt[1]);
                pending[1] = 1'b0;
                in_seq[1]++;
            end

            if (!v1 || e1) begin
                run_len = 0;
            end else if (e0 && run_len < STARVE) begin
                run_len++;
            end
            next_cycle();
        end

        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (out_seq[k] !== in_seq[k]) begin
                tests_failed++;
                $display("FAIL rand_loss stream=%0d got_out=%0d exp_out=%0d", k, out_seq[k], in_seq[k]);
            end
        end
        set_idle();
    endtask

    // ------------------------------------------------------------------
    initial begin
        set_idle();
        test_reset();
        test_umi0_stream();
        test_starve();
        test_backpressure();
        test_umi1_alone();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_umi_mux
`default_nettype wire
